// File: rtl/de_addkey_mixcolumn.sv
// ---------------------------------------------------------------------------
// de_addkey_mixcolumn
//   Decrypt-round stage that follows the inverse ShiftRows/SubBytes stage.
//   Stage A registers (iBlockIn ^ iRoundKey) with its round tag.
//   Stage B registers InvMixColumns(stage A), or stage A unchanged on the
//   final round (tag == NR_ROUNDS).
//
// Ports
//   clk, rst         single clock, asynchronous active-high reset
//   iBlockIn[127:0]  upstream state; byte 0 = [127:120], column c = [127-32c -: 32]
//   iRoundKey[127:0] round key, same byte order
//   iRound[3:0]      round tag, legal range 1..NR_ROUNDS
//   iValid / oReady  input handshake
//   oBlockOut[127:0] result block
//   oRound[3:0]      round tag travelling with oBlockOut
//   oValid / iReady  output handshake
//   oRoundErr        sticky: an out-of-range round tag was accepted
//
// Handshake: a word moves across an interface on a rising edge where both
//   valid and ready are 1. A producer holding valid=1 keeps its data stable
//   until that edge. oReady is derived from register state and iReady only,
//   never from iValid.
// ---------------------------------------------------------------------------
module de_addkey_mixcolumn #(
  parameter int NR_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] iBlockIn,
  input  logic [127:0] iRoundKey,
  input  logic [3:0]   iRound,
  input  logic         iValid,
  output logic         oReady,
  output logic [127:0] oBlockOut,
  output logic [3:0]   oRound,
  output logic         oValid,
  input  logic         iReady,
  output logic         oRoundErr
);

  localparam logic [3:0] LAST_ROUND = 4'(NR_ROUNDS);

  logic         valid_a_q, valid_a_d;
  logic [127:0] block_a_q, block_a_d;
  logic [3:0]   round_a_q, round_a_d;
  logic         valid_b_q, valid_b_d;
  logic [127:0] block_b_q, block_b_d;
  logic [3:0]   round_b_q, round_b_d;
  logic         round_err_q, round_err_d;

  logic         en_a, en_b, in_xfer, round_bad;
  logic [127:0] mixed, f_out;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; s0 is the top byte [31:24]
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Stage B may load when empty or draining; stage A when empty or moving on.
  assign en_b    = !valid_b_q | iReady;
  assign en_a    = !valid_a_q | en_b;
  assign oReady  = en_a;
  assign in_xfer = iValid & en_a;

  assign round_bad = (iRound == 4'd0) || (iRound > LAST_ROUND);

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(block_a_q[127-32*c -: 32]);
    end
  end

  assign f_out = (round_a_q == LAST_ROUND) ? block_a_q : mixed;

  always_comb begin
    valid_a_d   = valid_a_q;
    block_a_d   = block_a_q;
    round_a_d   = round_a_q;
    valid_b_d   = valid_b_q;
    block_b_d   = block_b_q;
    round_b_d   = round_b_q;
    round_err_d = round_err_q;

    if (en_a) begin
      valid_a_d = iValid;
      if (iValid) begin
        block_a_d = iBlockIn ^ iRoundKey;
        round_a_d = iRound;
      end
    end

    if (en_b) begin
      valid_b_d = valid_a_q;
      round_b_d = round_a_q;
      if (valid_a_q) begin
        block_b_d = f_out;
      end
    end

    // Bad tags are flagged but the block still flows through.
    if (in_xfer && round_bad) begin
      round_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_a_q   <= 1'b0;
      block_a_q   <= '0;
      round_a_q   <= '0;
      valid_b_q   <= 1'b0;
      block_b_q   <= '0;
      round_b_q   <= '0;
      round_err_q <= 1'b0;
    end else begin
      valid_a_q   <= valid_a_d;
      block_a_q   <= block_a_d;
      round_a_q   <= round_a_d;
      valid_b_q   <= valid_b_d;
      block_b_q   <= block_b_d;
      round_b_q   <= round_b_d;
      round_err_q <= round_err_d;
    end
  end

  assign oValid    = valid_b_q;
  assign oBlockOut = block_b_q;
  assign oRound    = round_b_q;
  assign oRoundErr = round_err_q;

endmodule

// File: tb/tb_de_addkey_mixcolumn.sv
// ---------------------------------------------------------------------------
// Testbench for de_addkey_mixcolumn. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_de_addkey_mixcolumn;

  localparam int NR = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] iBlockIn, iRoundKey, oBlockOut;
  logic [3:0]   iRound, oRound;
  logic         iValid, oReady, oValid, iReady, oRoundErr;

  int checks   = 0;
  int failures = 0;

  // scoreboard
  logic [127:0] exp_q[$];
  logic [3:0]   exp_round_q[$];

  logic         hold_vld = 1'b0;
  logic [127:0] hold_blk;
  logic [3:0]   hold_rnd;

  de_addkey_mixcolumn #(.NR_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .iBlockIn  (iBlockIn),
    .iRoundKey (iRoundKey),
    .iRound    (iRound),
    .iValid    (iValid),
    .oReady    (oReady),
    .oBlockOut (oBlockOut),
    .oRound    (oRound),
    .oValid    (oValid),
    .iReady    (iReady),
    .oRoundErr (oRoundErr)
  );

  // Reference model: shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_inv_mix(input logic [127:0] s);
    logic [127:0] r = '0;
    logic [7:0] coef [4];
    logic [7:0] c [4];
    logic [7:0] acc;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int col = 0; col < 4; col++) begin
      for (int i = 0; i < 4; i++) c[i] = s[127-32*col-8*i -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - row) & 3], c[j]);
        r[127-32*col-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] blk, input logic [127:0] key,
                                         input logic [3:0] rnd);
    logic [127:0] x = blk ^ key;
    return (rnd == 4'(NR)) ? x : model_inv_mix(x);
  endfunction

  // Output monitor: pops the scoreboard on every output transfer and checks
  // that a stalled output stays put.
  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        checks++;
        if (oValid !== 1'b1 || oBlockOut !== hold_blk || oRound !== hold_rnd) begin
          failures++;
          $display("FAIL stall_hold got v=%b blk=%h rnd=%0d required v=1 blk=%h rnd=%0d",
                   oValid, oBlockOut, oRound, hold_blk, hold_rnd);
        end
      end
      hold_vld = (oValid === 1'b1) && (iReady === 1'b0);
      hold_blk = oBlockOut;
      hold_rnd = oRound;
      if (oValid === 1'b1 && iReady === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got blk=%h rnd=%0d required none", oBlockOut, oRound);
        end else begin
          logic [127:0] eb;
          logic [3:0]   er;
          eb = exp_q.pop_front();
          er = exp_round_q.pop_front();
          if (oBlockOut !== eb || oRound !== er) begin
            failures++;
            $display("FAIL output got blk=%h rnd=%0d required blk=%h rnd=%0d",
                     oBlockOut, oRound, eb, er);
          end
        end
      end
    end
  end

  // driver: called 1 unit after a rising edge, returns 1 unit after the
  // edge on which the block was accepted
  task automatic send(input logic [127:0] blk, input logic [127:0] key,
                      input logic [3:0] rnd, input logic [127:0] expv);
    int n = 0;
    iValid = 1'b1; iBlockIn = blk; iRoundKey = key; iRound = rnd;
    forever begin
      @(negedge clk);
      if (oReady === 1'b1) begin
        exp_q.push_back(expv);
        exp_round_q.push_back(rnd);
        break;
      end
      n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL send_timeout got oReady=%b required 1", oReady);
        break;
      end
    end
    @(posedge clk); #1;
    iValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got remaining=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; iValid = 1'b0; iReady = 1'b1;
    iBlockIn = '0; iRoundKey = '0; iRound = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (oValid !== 1'b0 || oReady !== 1'b1 || oBlockOut !== '0 || oRound !== 4'd0 ||
        oRoundErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b rdy=%b blk=%h rnd=%0d err=%b required 0 1 0 0 0",
               oValid, oReady, oBlockOut, oRound, oRoundErr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    send({4{32'h8e4da1bc}}, '0, 4'd1, {4{32'hdb135345}});
    checks++;
    if (oValid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got oValid=%b required 0", oValid);
    end
    @(posedge clk); #1;
    checks++;
    if (oValid !== 1'b1 || oBlockOut !== {4{32'hdb135345}} || oRound !== 4'd1) begin
      failures++;
      $display("FAIL latency_two got v=%b blk=%h rnd=%0d required v=1 blk=%h rnd=1",
               oValid, oBlockOut, oRound, {4{32'hdb135345}});
    end
    drain("basic");
  endtask

  task automatic test_final_round;
    send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
         4'd10, 128'h00102030405060708090a0b0c0d0e0f0);
    drain("final_round");
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int first_drop = -1;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      iReady = !(cyc >= 2 && cyc <= 5);
      iValid = 1'b1; iBlockIn = {4{32'h9fdc589d}}; iRoundKey = '0; iRound = 4'(idx + 1);
      @(negedge clk);
      if (oReady === 1'b0 && first_drop < 0) first_drop = idx;
      if (oReady === 1'b1) begin
        exp_q.push_back({4{32'hf20a225c}});
        exp_round_q.push_back(4'(idx + 1));
        idx++;
      end
      @(posedge clk); #1;
    end
    iValid = 1'b0; iReady = 1'b1;
    checks++;
    if (first_drop != 2) begin
      failures++;
      $display("FAIL b2b_ready_drop got accepted_before_drop=%0d required 2", first_drop);
    end
    checks++;
    if (idx != 4) begin
      failures++;
      $display("FAIL b2b_accepted got %0d required 4", idx);
    end
    drain("b2b");
  endtask

  task automatic test_random;
    int idx = 0;
    logic [127:0] blk, key;
    logic [3:0]   rnd;
    blk = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    rnd = 4'($urandom_range(1, NR));
    for (int cyc = 0; cyc < 200 && idx < 12; cyc++) begin
      iReady = ($urandom_range(0, 3) != 0);
      iValid = ($urandom_range(0, 4) != 0);
      iBlockIn = blk; iRoundKey = key; iRound = rnd;
      @(negedge clk);
      if (iValid && oReady === 1'b1) begin
        exp_q.push_back(model(blk, key, rnd));
        exp_round_q.push_back(rnd);
        idx++;
        blk = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        rnd = 4'($urandom_range(1, NR));
      end
      @(posedge clk); #1;
    end
    iValid = 1'b0; iReady = 1'b1;
    drain("random");
  endtask

  task automatic test_round_err;
    @(negedge clk);
    checks++;
    if (oRoundErr !== 1'b0) begin
      failures++;
      $display("FAIL round_err_clean got %b required 0", oRoundErr);
    end
    @(posedge clk); #1;
    send({4{32'h8e4da1bc}}, '0, 4'd0, {4{32'hdb135345}});
    @(negedge clk);
    checks++;
    if (oRoundErr !== 1'b1) begin
      failures++;
      $display("FAIL round_err_zero got %b required 1", oRoundErr);
    end
    @(posedge clk); #1;
    send({4{32'h8e4da1bc}}, '0, 4'd11, {4{32'hdb135345}});
    drain("round_err");
    @(negedge clk);
    checks++;
    if (oRoundErr !== 1'b1) begin
      failures++;
      $display("FAIL round_err_sticky got %b required 1", oRoundErr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    iReady = 1'b0;
    send({4{32'h8e4da1bc}}, '0, 4'd1, '0);
    send({4{32'h9fdc589d}}, '0, 4'd2, '0);
    @(negedge clk);
    checks++;
    if (oValid !== 1'b1 || oReady !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_full got v=%b rdy=%b required v=1 rdy=0", oValid, oReady);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (oValid !== 1'b0 || oReady !== 1'b1 || oRoundErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async got v=%b rdy=%b err=%b required 0 1 0",
               oValid, oReady, oRoundErr);
    end
    exp_q.delete();
    exp_round_q.delete();
    iReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (oValid !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet got oValid=%b required 0 (cycle %0d)", oValid, i);
      end
    end
    @(posedge clk); #1;
    send({4{32'h9fdc589d}}, '0, 4'd3, {4{32'hf20a225c}});
    drain("after_reset");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_final_round;
    test_back_to_back;
    test_random;
    test_round_err;
    test_reset_mid;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
